// File: rtl/sram_burst_master.sv
// Burst master for a single-port SRAM: turns (addr, len, dir) requests into
// per-beat SRAM accesses, with a write-data input stream and a 2-entry read
// FIFO feeding a backpressured read-data output stream.
module sram_burst_master #(
  parameter int unsigned SRAM_DEPTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned LEN_WIDTH  = 5
) (
  input  logic                  iClk,
  input  logic                  iRsn,
  input  logic                  iReqVld,
  output logic                  oReqRdy,
  input  logic                  iReqWrn,
  input  logic [ADDR_WIDTH-1:0] iReqAddr,
  input  logic [LEN_WIDTH-1:0]  iReqLen,
  input  logic                  iWrVld,
  output logic                  oWrRdy,
  input  logic [DATA_WIDTH-1:0] iWrDt,
  output logic                  oRdVld,
  input  logic                  iRdRdy,
  output logic [DATA_WIDTH-1:0] oRdDt,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oCsn,
  output logic                  oWrn,
  output logic [ADDR_WIDTH-1:0] oAddr,
  output logic [DATA_WIDTH-1:0] oWrDt,
  input  logic [DATA_WIDTH-1:0] iRdDt
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SRAM_DEPTH - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic                  r_pend;
  logic [DATA_WIDTH-1:0] r_fifo [2];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_cnt;

  logic                  w_rem_nz;
  logic                  w_pop;
  logic                  w_push;
  logic [2:0]            w_credit;
  logic                  w_wr_beat;
  logic                  w_rd_issue;
  logic [1:0]            w_cnt_after_pop;
  logic [1:0]            w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  // Beat qualification and read-credit accounting
  assign w_rem_nz        = (r_rem != '0);
  assign w_pop           = (r_cnt != 2'd0) && iRdRdy;
  assign w_push          = r_pend;
  assign w_credit        = 3'(r_cnt) + 3'(r_pend) - 3'(w_pop);
  assign w_wr_beat       = (r_state == S_WRITE) && w_rem_nz && iWrVld;
  assign w_rd_issue      = (r_state == S_READ) && w_rem_nz && (w_credit < 3'd2);
  assign w_cnt_after_pop = r_cnt - 2'(w_pop);
  assign w_cnt_nxt       = r_cnt + 2'(w_push) - 2'(w_pop);
  assign w_next_addr     = (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;

  // Control flags decoded directly from registered state
  assign oReqRdy = (r_state == S_IDLE);
  assign oWrRdy  = (r_state == S_WRITE) && w_rem_nz;
  assign oBusy   = (r_state != S_IDLE);
  assign oDone   = (r_state == S_DONE);
  assign oRdVld  = (r_cnt != 2'd0);
  assign oRdDt   = r_fifo[r_rd_ptr];

  // SRAM command: driven only in a cycle that issues a beat, idle otherwise
  always_comb begin
    oCsn  = 1'b1;
    oWrn  = 1'b1;
    oAddr = '0;
    oWrDt = '0;
    if (w_wr_beat) begin
      oCsn  = 1'b0;
      oWrn  = 1'b0;
      oAddr = r_addr;
      oWrDt = iWrDt;
    end else if (w_rd_issue) begin
      oCsn  = 1'b0;
      oAddr = r_addr;
    end
  end

  // Burst FSM, address/length tracking and read FIFO
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_rem     <= '0;
      r_pend    <= 1'b0;
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_cnt     <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= iRdDt;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_cnt  <= w_cnt_nxt;
      r_pend <= w_rd_issue;

      case (r_state)
        S_IDLE: begin
          if (iReqVld) begin
            r_addr <= iReqAddr;
            r_rem  <= iReqLen;
            if (iReqLen == '0)  r_state <= S_DONE;
            else if (iReqWrn)   r_state <= S_READ;
            else                r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_wr_beat) begin
            r_addr <= w_next_addr;
            r_rem  <= r_rem - 1'b1;
            if (r_rem == LEN_WIDTH'(1)) r_state <= S_DONE;
          end
        end
        S_READ: begin
          if (w_rd_issue) begin
            r_addr <= w_next_addr;
            r_rem  <= r_rem - 1'b1;
          end
          // Finish once nothing is left to issue, in flight, or buffered
          if (!w_rem_nz && !r_pend && (w_cnt_after_pop == 2'd0)) r_state <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst_master.sv
// Randomized self-checking bench for sram_burst_master with an SRAM model and
// a golden memory image as reference.
module tb_sram_burst_master;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned LW    = 5;
  localparam int unsigned DEPTH = 16;

  logic          iClk = 1'b0;
  logic          iRsn;
  logic          iReqVld;
  logic          oReqRdy;
  logic          iReqWrn;
  logic [AW-1:0] iReqAddr;
  logic [LW-1:0] iReqLen;
  logic          iWrVld;
  logic          oWrRdy;
  logic [DW-1:0] iWrDt;
  logic          oRdVld;
  logic          iRdRdy;
  logic [DW-1:0] oRdDt;
  logic          oBusy;
  logic          oDone;
  logic          oCsn;
  logic          oWrn;
  logic [AW-1:0] oAddr;
  logic [DW-1:0] oWrDt;
  logic [DW-1:0] iRdDt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] sram_mem [DEPTH];
  logic [DW-1:0] gold     [DEPTH];

  sram_burst_master #(
    .SRAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .iClk(iClk), .iRsn(iRsn),
    .iReqVld(iReqVld), .oReqRdy(oReqRdy), .iReqWrn(iReqWrn),
    .iReqAddr(iReqAddr), .iReqLen(iReqLen),
    .iWrVld(iWrVld), .oWrRdy(oWrRdy), .iWrDt(iWrDt),
    .oRdVld(oRdVld), .iRdRdy(iRdRdy), .oRdDt(oRdDt),
    .oBusy(oBusy), .oDone(oDone),
    .oCsn(oCsn), .oWrn(oWrn), .oAddr(oAddr), .oWrDt(oWrDt),
    .iRdDt(iRdDt)
  );

  always #5 iClk = ~iClk;

  // Single-port SRAM with registered read data
  always @(posedge iClk) begin
    if (!oCsn) begin
      if (!oWrn) sram_mem[oAddr] <= oWrDt;
      else       iRdDt <= sram_mem[oAddr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    return AW'((32'(a) + 1) % DEPTH);
  endfunction

  // Present a request and let it be accepted on the next edge
  task automatic req(input logic wrn, input logic [AW-1:0] addr, input int len);
    iReqVld  = 1'b1;
    iReqWrn  = wrn;
    iReqAddr = addr;
    iReqLen  = LW'(len);
    @(negedge iClk);
    chk("req_rdy", 32'(oReqRdy), 32'd1);
    chk("idle_csn", 32'(oCsn), 32'd1);
    @(posedge iClk); #1;
    iReqVld  = 1'b0;
    iReqWrn  = 1'($urandom_range(0, 1));
    iReqAddr = AW'($urandom);
    iReqLen  = LW'($urandom);
  endtask

  // One-cycle done pulse, then idle
  task automatic done_check();
    iReqVld = 1'b0;
    @(negedge iClk);
    chk("done_pulse", 32'(oDone), 32'd1);
    chk("done_busy", 32'(oBusy), 32'd1);
    chk("done_csn", 32'(oCsn), 32'd1);
    chk("done_rdvld", 32'(oRdVld), 32'd0);
    @(posedge iClk); #1;
    @(negedge iClk);
    chk("done_clear", 32'(oDone), 32'd0);
    chk("idle_busy", 32'(oBusy), 32'd0);
    @(posedge iClk); #1;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input int len, input bit hold);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int beat, cyc;
    req(1'b0, addr, len);
    a = addr; beat = 0; cyc = 0;
    while (beat < len && cyc < 400) begin
      d       = DW'($urandom);
      iWrDt   = d;
      iWrVld  = hold ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      iReqVld = 1'($urandom_range(0, 1));
      @(negedge iClk);
      chk("wr_busy", 32'(oBusy), 32'd1);
      chk("wr_rdy", 32'(oWrRdy), 32'd1);
      chk("wr_reqrdy", 32'(oReqRdy), 32'd0);
      if (iWrVld) begin
        chk("wr_csn", 32'(oCsn), 32'd0);
        chk("wr_wrn", 32'(oWrn), 32'd0);
        chk("wr_addr", 32'(oAddr), 32'(a));
        chk("wr_data", 32'(oWrDt), 32'(d));
        gold[a] = d;
        a = wrap_inc(a);
        beat++;
      end else begin
        chk("wr_gap_csn", 32'(oCsn), 32'd1);
      end
      @(posedge iClk); #1;
      cyc++;
    end
    iWrVld  = 1'b0;
    iReqVld = 1'b0;
    chk("wr_beats", 32'(beat), 32'(len));
    if (hold) chk("wr_cycles", 32'(cyc), 32'(len));
    done_check();
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0 repeating, 2: random
  task automatic do_read(input logic [AW-1:0] addr, input int len, input int mode);
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] held;
    logic [AW-1:0] a, ia;
    int issued, got, cyc, first_iss, first_vld, last_pop;
    bit stalled;
    a = addr;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(gold[a]);
      a = wrap_inc(a);
    end
    req(1'b1, addr, len);
    ia = addr; issued = 0; got = 0; cyc = 0;
    first_iss = -1; first_vld = -1; last_pop = 0; stalled = 1'b0; held = '0;
    while (got < len && cyc < 400) begin
      case (mode)
        0:       iRdRdy = 1'b1;
        1:       iRdRdy = 1'((cyc % 3) == 0);
        default: iRdRdy = 1'($urandom_range(0, 1));
      endcase
      iReqVld = 1'($urandom_range(0, 1));
      @(negedge iClk);
      chk("rd_busy", 32'(oBusy), 32'd1);
      if (stalled) begin
        chk("rd_hold_vld", 32'(oRdVld), 32'd1);
        chk("rd_hold_dt", 32'(oRdDt), 32'(held));
      end
      if (!oCsn) begin
        chk("rd_wrn", 32'(oWrn), 32'd1);
        chk("rd_addr", 32'(oAddr), 32'(ia));
        chk("rd_over_issue", 32'(issued < len), 32'd1);
        ia = wrap_inc(ia);
        issued++;
        if (first_iss < 0) first_iss = cyc;
      end
      if (oRdVld && first_vld < 0) first_vld = cyc;
      if (oRdVld && iRdRdy) begin
        chk("rd_data", 32'(oRdDt), 32'(exp_q[got]));
        got++;
        last_pop = cyc;
      end
      chk("rd_outstanding", 32'((issued - got) <= 2), 32'd1);
      stalled = oRdVld && !iRdRdy;
      held    = oRdDt;
      @(posedge iClk); #1;
      cyc++;
    end
    iRdRdy  = 1'b0;
    iReqVld = 1'b0;
    chk("rd_beats", 32'(got), 32'(len));
    if (mode == 0) begin
      chk("rd_first_issue", 32'(first_iss), 32'd0);
      chk("rd_latency", 32'(first_vld - first_iss), 32'd2);
      chk("rd_stream_len", 32'(last_pop - first_vld), 32'(len - 1));
    end
    done_check();
  endtask

  initial begin
    int n, cyc;
    iRsn = 1'b0; iReqVld = 1'b0; iReqWrn = 1'b0; iReqAddr = '0; iReqLen = '0;
    iWrVld = 1'b0; iWrDt = '0; iRdRdy = 1'b0;
    #3;
    chk("rst_csn", 32'(oCsn), 32'd1);
    chk("rst_wrn", 32'(oWrn), 32'd1);
    chk("rst_addr", 32'(oAddr), 32'd0);
    chk("rst_wrdt", 32'(oWrDt), 32'd0);
    chk("rst_reqrdy", 32'(oReqRdy), 32'd1);
    chk("rst_wrrdy", 32'(oWrRdy), 32'd0);
    chk("rst_rdvld", 32'(oRdVld), 32'd0);
    chk("rst_rddt", 32'(oRdDt), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_done", 32'(oDone), 32'd0);
    @(negedge iClk); @(negedge iClk);
    iRsn = 1'b1;
    @(posedge iClk); #1;

    do_write(AW'(0), 16, 1'b1);
    do_write(AW'(3), 4, 1'b1);
    do_read(AW'(3), 4, 0);
    do_write(AW'(14), 4, 1'b1);
    do_read(AW'(14), 4, 0);
    do_write(AW'(0), 6, 1'b1);
    do_read(AW'(0), 6, 1);

    // Zero-length requests touch no SRAM and complete in one busy cycle
    req(1'b0, AW'(7), 0);
    done_check();
    req(1'b1, AW'(9), 0);
    done_check();

    // Reset during beat 3 issue of a 5-beat read
    req(1'b1, AW'(0), 5);
    iRdRdy = 1'b1;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 20) begin
      @(negedge iClk);
      if (!oCsn) n++;
      @(posedge iClk); #1;
      cyc++;
    end
    chk("rst_mid_setup", 32'(n), 32'd2);
    chk("rst_mid_pre_csn", 32'(oCsn), 32'd0);
    #2 iRsn = 1'b0;
    #1;
    chk("rst_mid_csn", 32'(oCsn), 32'd1);
    chk("rst_mid_rdvld", 32'(oRdVld), 32'd0);
    chk("rst_mid_busy", 32'(oBusy), 32'd0);
    chk("rst_mid_done", 32'(oDone), 32'd0);
    chk("rst_mid_reqrdy", 32'(oReqRdy), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge iClk);
      chk("rst_hold_done", 32'(oDone), 32'd0);
      chk("rst_hold_csn", 32'(oCsn), 32'd1);
    end
    iRdRdy = 1'b0;
    iRsn = 1'b1;
    @(negedge iClk);
    chk("rst_after_done", 32'(oDone), 32'd0);
    chk("rst_after_busy", 32'(oBusy), 32'd0);
    @(posedge iClk); #1;
    do_read(AW'(0), 5, 0);

    // Random bursts with random stalls on both streams
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(AW'($urandom), int'($urandom_range(1, 31)), 1'($urandom_range(0, 1)));
      else
        do_read(AW'($urandom), int'($urandom_range(1, 31)), int'($urandom_range(1, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
